// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage.
//
// Registers the execute-to-memory bus, turns it into a bubble or holds it
// under stall control, and aligns/extends load data returned by the
// synchronous data SRAM. The register-file write and the HI/LO write are
// forwarded to write-back, and the same values are exposed to decode for
// forwarding.
//
// Ports:
//   clk              clock
//   rst              synchronous reset, active-high
//   stall[5:0]       pipeline stall vector; stall[3] holds this stage's input,
//                    stall[4] holds the write-back stage's input
//   ex_to_mem_bus    {mem_op[2:0], hilo_we, hilo_result[63:0], pc[31:0],
//                     data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we,
//                     rf_waddr[4:0], ex_result[31:0]}
//   data_sram_rdata  SRAM read data for the op currently held in bus_r
//   mem_to_wb_bus    {hilo_we, hilo_wdata[63:0], pc[31:0], rf_we,
//                     rf_waddr[4:0], rf_wdata[31:0]}
//   mem_to_id_bus    {hilo_we, hilo_wdata[63:0], rf_we, rf_waddr[4:0],
//                     rf_wdata[31:0]}
//   mem_is_load      registered op is a load (data_ram_en=1, data_ram_wen=0)
//
// Stall semantics: there is no valid/ready handshake here. When stall[3] is
// set and stall[4] is clear, this stage cannot accept new input but write-back
// can, so a bubble (all zeros, every write enable 0) is loaded. When both are
// set the register holds. Without stall[3] the register takes the new input.
// The SRAM is not stalled by this block; upstream keeps the address steady.

module mem_stage #(
    parameter int IN_WD  = 144,
    parameter int WB_WD  = 135,
    parameter int FWD_WD = 103
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [IN_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]       data_sram_rdata,
    output logic [WB_WD-1:0]  mem_to_wb_bus,
    output logic [FWD_WD-1:0] mem_to_id_bus,
    output logic              mem_is_load
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic [IN_WD-1:0] bus_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= '0;
        end else if (stall[3] && !stall[4]) begin
            bus_r <= '0;
        end else if (!stall[3]) begin
            bus_r <= ex_to_mem_bus;
        end
    end

    // Field decode of the registered bus
    logic [2:0]  mem_op;
    logic        hilo_we;
    logic [63:0] hilo_result;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign mem_op       = bus_r[143:141];
    assign hilo_we      = bus_r[140];
    assign hilo_result  = bus_r[139:76];
    assign pc           = bus_r[75:44];
    assign data_ram_en  = bus_r[43];
    assign data_ram_wen = bus_r[42:39];
    assign sel_rf_res   = bus_r[38];
    assign rf_we        = bus_r[37];
    assign rf_waddr     = bus_r[36:32];
    assign ex_result    = bus_r[31:0];

    // Little-endian lane select; for halves addr[0] is ignored and
    // misalignment is deliberately not trapped.
    logic [1:0]  addr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign addr = ex_result[1:0];

    always_comb begin
        byte_sel = data_sram_rdata[7:0];
        case (addr)
            2'd0: byte_sel = data_sram_rdata[7:0];
            2'd1: byte_sel = data_sram_rdata[15:8];
            2'd2: byte_sel = data_sram_rdata[23:16];
            2'd3: byte_sel = data_sram_rdata[31:24];
            default: byte_sel = data_sram_rdata[7:0];
        endcase
        half_sel = addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    end

    // Encodings 101..111 fall through to a full-word load.
    always_comb begin
        load_data = data_sram_rdata;
        case (mem_op)
            OP_LW:   load_data = data_sram_rdata;
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            default: load_data = data_sram_rdata;
        endcase
    end

    logic [31:0] rf_wdata;
    assign rf_wdata = sel_rf_res ? load_data : ex_result;

    assign mem_is_load = data_ram_en && (data_ram_wen == 4'b0000);

    assign mem_to_wb_bus = {hilo_we, hilo_result, pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {hilo_we, hilo_result, rf_we, rf_waddr, rf_wdata};

    // Stall bits owned by other stages are not used here.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

endmodule
